// File: rtl/uart_tx_feeder_if.sv
// Byte stream into the uart TX feeder.
// Transfer happens on a rising edge where s_valid && s_ready. The source holds s_data
// stable while s_valid is high and not yet accepted. s_ready does not depend on s_valid.
interface uart_tx_feeder_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus load sequencer feeding the uart TX load interface.
// Paces loads on tx_empty and flags a sticky error when the uart never goes busy.
module uart_tx_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int BUSY_TO = 15
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_feeder_if.slave  s,
  input  logic             flush,
  output logic             ld_tx_data,
  output logic [7:0]       tx_data,
  output logic             tx_enable,
  input  logic             tx_empty,
  output logic [AW:0]      level,
  output logic             idle,
  output logic             load_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int TW = $clog2(BUSY_TO + 1);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] timer;
  logic          push;
  logic          pop;
  logic [AW:0]   level_next;

  assign dbg_state = state;

  // Flush wins over a same-cycle write; a same-cycle pop still takes the head byte.
  always_comb begin
    push       = s.s_valid && s.s_ready && !flush;
    pop        = (state == IDLE) && (level != '0) && tx_empty;
    level_next = level;
    if (flush)
      level_next = '0;
    else
      level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s.s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      timer      <= '0;
      s.s_ready  <= 1'b0;
      ld_tx_data <= 1'b0;
      tx_data    <= 8'h00;
      tx_enable  <= 1'b0;
      idle       <= 1'b1;
      load_err   <= 1'b0;
    end else begin
      level     <= level_next;
      s.s_ready <= (level_next != (AW+1)'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      tx_enable  <= (state != IDLE) || (level != '0);
      idle       <= (state == IDLE) && (level == '0);
      ld_tx_data <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            state   <= LOAD;
          end
        end
        LOAD: begin
          ld_tx_data <= 1'b1;
          timer      <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A uart that never reports busy still counts the byte as sent.
          if (!tx_empty) begin
            state <= WAIT_DONE;
          end else if (timer == TW'(BUSY_TO - 1)) begin
            load_err <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed/random bench for uart_tx_feeder with a queue-based byte scoreboard
// and a small behavioural uart that goes busy after each load strobe.
module tb_uart_tx_feeder;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int BUSY_TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          tx_empty = 1'b1;
  logic          ld_tx_data;
  logic [7:0]    tx_data;
  logic          tx_enable;
  logic [AW:0]   level;
  logic          idle;
  logic          load_err;
  logic [1:0]    dbg_state;

  uart_tx_feeder_if sif ();

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .BUSY_TO(BUSY_TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (sif.slave),
    .flush      (flush),
    .ld_tx_data (ld_tx_data),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_empty   (tx_empty),
    .level      (level),
    .idle       (idle),
    .load_err   (load_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe = 0;
  int max_level = 0;
  bit have_prev = 0;
  bit prev_ld = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      have_prev = 0;
      prev_ld = 0;
    end else begin
      if (int'(level) > max_level) max_level = int'(level);
      if (ld_tx_data === 1'b1) begin
        check("ld_single_cycle", 32'(prev_ld), 32'd0);
        if (have_prev) check("strobe_gap_ge4", 32'((cyc - last_strobe) >= 4), 32'd1);
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
        strobe_cnt++;
        last_strobe = cyc;
        have_prev = 1;
      end
      prev_ld = (ld_tx_data === 1'b1);
    end
  end

  // Uart model: in hold mode tx_empty follows hold_val; otherwise it goes low one
  // cycle after a load strobe and stays low for 10 cycles.
  bit   hold_mode = 1;
  logic hold_val = 1'b1;
  int   busy = 0;
  bit   pending = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (hold_mode) begin
        tx_empty = hold_val;
        busy = 0;
        pending = 0;
      end else if (pending) begin
        tx_empty = 1'b0;
        busy = 10;
        pending = 0;
      end else if (busy > 0) begin
        busy--;
        tx_empty = (busy == 0);
      end else begin
        tx_empty = 1'b1;
      end
      if (!hold_mode && ld_tx_data === 1'b1) pending = 1;
    end
  end

  int last_acc_cyc = 0;

  // Called at a falling edge; returns at a falling edge with s_valid low.
  task automatic send_byte(input logic [7:0] b, input int max_wait, output bit acc);
    bit rdy;
    acc = 0;
    sif.s_valid = 1'b1;
    sif.s_data = b;
    for (int i = 0; i < max_wait && !acc; i++) begin
      rdy = sif.s_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1;
        exp_q.push_back(b);
      end
      @(negedge clk);
      if (acc) last_acc_cyc = cyc;
    end
    sif.s_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(strobe_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(idle === 1'b1 && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(idle === 1'b1 && exp_q.size() == 0), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int base;
    int first;
    int n;
    int drops;
    logic [7:0] b;

    // Reset
    sif.s_valid = 1'b0;
    sif.s_data = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(sif.s_ready), 32'd0);
    check("rst_ld", 32'(ld_tx_data), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("s_ready_after_rst", 32'(sif.s_ready), 32'd1);

    // Single byte
    hold_mode = 0;
    @(negedge clk);
    send_byte(8'hA5, 4, acc);
    check("a5_accepted", 32'(acc), 32'd1);
    wait_strobes(1, 20, "a5_strobe_seen");
    check("a5_latency", 32'(last_strobe - last_acc_cyc), 32'd2);
    check("a5_tx_data", 32'(tx_data), 32'hA5);
    wait_idle(100, "a5_idle");
    check("a5_one_strobe", 32'(strobe_cnt), 32'd1);
    check("a5_level", 32'(level), 32'd0);

    // Fill with uart held busy
    hold_mode = 1;
    hold_val = 1'b0;
    repeat (2) @(negedge clk);
    base = strobe_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i), 1, acc);
      check("fill_accept", 32'(acc), 32'd1);
    end
    check("fill_level", 32'(level), 32'(DEPTH));
    check("fill_ready_low", 32'(sif.s_ready), 32'd0);
    send_byte(8'd16, 3, acc);
    check("fill_byte16_rejected", 32'(acc), 32'd0);
    check("fill_level_hold", 32'(level), 32'(DEPTH));
    check("fill_no_load", 32'(strobe_cnt), 32'(base));
    hold_mode = 0;
    wait_strobes(base + DEPTH, 600, "fill_drain");
    wait_idle(100, "fill_idle");
    repeat (10) @(negedge clk);
    check("fill_strobes", 32'(strobe_cnt), 32'(base + DEPTH));

    // Random stream across pointer wrap
    max_level = 0;
    base = strobe_cnt;
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, 100, acc);
      if (!acc) drops++;
    end
    check("wrap_no_drops", 32'(drops), 32'd0);
    wait_strobes(base + 40, 1000, "wrap_drain");
    wait_idle(100, "wrap_idle");
    check("wrap_strobes", 32'(strobe_cnt), 32'(base + 40));
    check("wrap_max_level", 32'(max_level), 32'(DEPTH));

    // Timeout: uart never reports busy
    hold_mode = 1;
    hold_val = 1'b1;
    repeat (2) @(negedge clk);
    check("to_err_clear", 32'(load_err), 32'd0);
    base = strobe_cnt;
    send_byte(8'($urandom_range(0, 255)), 2, acc);
    send_byte(8'($urandom_range(0, 255)), 2, acc);
    wait_strobes(base + 1, 20, "to_first_strobe");
    first = last_strobe;
    repeat (BUSY_TO - 1) @(negedge clk);
    check("to_err_not_yet", 32'(load_err), 32'd0);
    check("to_state_wait", 32'(dbg_state), 32'd2);
    @(negedge clk);
    check("to_err_set", 32'(load_err), 32'd1);
    check("to_state_idle", 32'(dbg_state), 32'd0);
    wait_strobes(base + 2, 30, "to_second_strobe");
    check("to_second_gap", 32'(last_strobe - first), 32'(BUSY_TO + 2));
    wait_idle(60, "to_idle");
    check("to_err_sticky", 32'(load_err), 32'd1);

    // Flush while first byte is in flight
    hold_val = 1'b0;
    repeat (2) @(negedge clk);
    base = strobe_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 2, acc);
    check("fl_level5", 32'(level), 32'd5);
    hold_mode = 0;
    wait_strobes(base + 1, 20, "fl_first_strobe");
    n = 0;
    while (dbg_state !== 2'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fl_in_wait_done", 32'(dbg_state), 32'd3);
    flush = 1'b1;
    sif.s_valid = 1'b1;
    sif.s_data = 8'hEE;
    @(negedge clk);
    flush = 1'b0;
    sif.s_valid = 1'b0;
    exp_q.delete();
    check("fl_level0", 32'(level), 32'd0);
    repeat (60) @(negedge clk);
    check("fl_no_more_strobes", 32'(strobe_cnt), 32'(base + 1));
    check("fl_idle", 32'(idle), 32'd1);
    check("fl_level_end", 32'(level), 32'd0);
    check("fl_state_end", 32'(dbg_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
